// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite bus arbiter: picks the address-phase owner among
// num_masters requesters, muxes its address phase and the data-phase owner's HWDATA.
module ahb_arbiter #(
  parameter int num_masters = 2,
  parameter int max_beats   = 16,
  localparam int mw = (num_masters > 1) ? $clog2(num_masters) : 1
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [num_masters-1:0]       HBUSREQ,
  input  logic [num_masters-1:0]       HLOCK,
  input  logic [num_masters-1:0][31:0] M_HADDR,
  input  logic [num_masters-1:0][1:0]  M_HTRANS,
  input  logic [num_masters-1:0]       M_HWRITE,
  input  logic [num_masters-1:0][2:0]  M_HSIZE,
  input  logic [num_masters-1:0][31:0] M_HWDATA,
  input  logic                         HREADY,
  output logic [num_masters-1:0]       HGRANT,
  output logic [mw-1:0]                HMASTER,
  output logic [mw-1:0]                HMASTER_D,
  output logic                         HMASTLOCK,
  output logic [31:0]                  HADDR,
  output logic [1:0]                   HTRANS,
  output logic                         HWRITE,
  output logic [2:0]                   HSIZE,
  output logic [31:0]                  HWDATA
);

  localparam int bw = $clog2(max_beats + 1);
  localparam logic [bw:0]            max_ext   = (bw + 1)'(max_beats);
  localparam logic [num_masters-1:0] grant_rst = num_masters'(1);

  logic [mw-1:0]          owner_q, owner_d;
  logic [mw-1:0]          data_owner_q, data_owner_d;
  logic [num_masters-1:0] grant_q, grant_d;
  logic [bw-1:0]          beat_cnt_q, beat_cnt_d;
  logic                   locked_q, locked_d;

  logic          own_req, own_lock;
  logic          counted, other_req, lock_hold, keep_vol;
  logic [bw:0]   beat_sum;
  logic [mw-1:0] rr_owner, idx;
  logic          rr_found;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    HADDR    = '0;
    HTRANS   = '0;
    HWRITE   = 1'b0;
    HSIZE    = '0;
    HWDATA   = '0;
    own_req  = 1'b0;
    own_lock = 1'b0;
    for (int i = 0; i < num_masters; i++) begin
      if (owner_q == mw'(i)) begin
        HADDR    = M_HADDR[mw'(i)];
        HTRANS   = M_HTRANS[mw'(i)];
        HWRITE   = M_HWRITE[mw'(i)];
        HSIZE    = M_HSIZE[mw'(i)];
        own_req  = HBUSREQ[mw'(i)];
        own_lock = HLOCK[mw'(i)];
      end
      if (data_owner_q == mw'(i)) begin
        HWDATA = M_HWDATA[mw'(i)];
      end
    end
  end

  assign HMASTLOCK = own_lock & own_req;

  // Round-robin search skips the owner; falling back to it parks the bus.
  always_comb begin
    rr_owner = owner_q;
    rr_found = 1'b0;
    idx      = '0;
    for (int k = 1; k < num_masters; k++) begin
      idx = mw'((int'(owner_q) + k) % num_masters);
      if (!rr_found && HBUSREQ[idx]) begin
        rr_found = 1'b1;
        rr_owner = idx;
      end
    end
  end

  always_comb begin
    counted   = HTRANS[1];
    beat_sum  = {1'b0, beat_cnt_q} + {{bw{1'b0}}, counted};
    other_req = |(HBUSREQ & ~grant_q);
    // Lock tenure covers the last locked transfer, issued after HLOCK drops.
    lock_hold = HMASTLOCK | (locked_q & counted);
    keep_vol  = own_req & ((beat_sum < max_ext) | ~other_req);

    owner_d      = owner_q;
    data_owner_d = data_owner_q;
    beat_cnt_d   = beat_cnt_q;
    locked_d     = locked_q;
    if (HREADY) begin
      owner_d      = (lock_hold || keep_vol) ? owner_q : rr_owner;
      data_owner_d = owner_q;
      locked_d     = HMASTLOCK;
      if (owner_d != owner_q) begin
        beat_cnt_d = '0;
      end else if (beat_sum >= max_ext) begin
        beat_cnt_d = bw'(max_beats);
      end else begin
        beat_cnt_d = beat_sum[bw-1:0];
      end
    end
    grant_d = grant_rst << owner_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q      <= '0;
      data_owner_q <= '0;
      grant_q      <= grant_rst;
      beat_cnt_q   <= '0;
      locked_q     <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      data_owner_q <= data_owner_d;
      grant_q      <= grant_d;
      beat_cnt_q   <= beat_cnt_d;
      locked_q     <= locked_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = owner_q;
  assign HMASTER_D = data_owner_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboarded random + directed bench for ahb_arbiter (3 masters, max_beats 4).
module tb_ahb_arbiter;
  localparam int N    = 3;
  localparam int MAXB = 4;
  localparam int MW   = 2;

  logic                HCLK = 1'b0;
  logic                HRESETn = 1'b0;
  logic [N-1:0]        HBUSREQ = '0;
  logic [N-1:0]        HLOCK = '0;
  logic [N-1:0][31:0]  M_HADDR = '0;
  logic [N-1:0][1:0]   M_HTRANS = '0;
  logic [N-1:0]        M_HWRITE = '0;
  logic [N-1:0][2:0]   M_HSIZE = '0;
  logic [N-1:0][31:0]  M_HWDATA = '0;
  logic                HREADY = 1'b0;
  logic [N-1:0]        HGRANT;
  logic [MW-1:0]       HMASTER, HMASTER_D;
  logic                HMASTLOCK, HWRITE;
  logic [31:0]         HADDR, HWDATA;
  logic [1:0]          HTRANS;
  logic [2:0]          HSIZE;

  always #5 HCLK = ~HCLK;

  ahb_arbiter #(.num_masters(N), .max_beats(MAXB)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE),
    .M_HSIZE(M_HSIZE), .M_HWDATA(M_HWDATA), .HREADY(HREADY),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTER_D(HMASTER_D),
    .HMASTLOCK(HMASTLOCK), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA)
  );

  typedef struct {
    logic [N-1:0]  grant;
    logic [MW-1:0] hm, hmd;
    logic          lock;
    logic [31:0]   addr;
    logic [1:0]    trans;
    logic          wr;
    logic [2:0]    size;
    logic [31:0]   wdata;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: who owns the bus, who owns the data phase, beats in tenure.
  int m_owner = 0, m_downer = 0, m_beats = 0;
  bit m_locked = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.grant = N'(1) << m_owner;
    e.hm    = MW'(m_owner);
    e.hmd   = MW'(m_downer);
    e.lock  = HLOCK[MW'(m_owner)] & HBUSREQ[MW'(m_owner)];
    e.addr  = M_HADDR[MW'(m_owner)];
    e.trans = M_HTRANS[MW'(m_owner)];
    e.wr    = M_HWRITE[MW'(m_owner)];
    e.size  = M_HSIZE[MW'(m_owner)];
    e.wdata = M_HWDATA[MW'(m_downer)];
    return e;
  endfunction

  function automatic void model_reset();
    m_owner = 0; m_downer = 0; m_beats = 0; m_locked = 1'b0;
  endfunction

  // Applies one clock edge's worth of arbitration to the model.
  function automatic void advance();
    int  o, nxt, total;
    bit  counted, others, req_o, lock_o;
    if (!HREADY) return;
    o       = m_owner;
    req_o   = HBUSREQ[MW'(o)];
    lock_o  = HLOCK[MW'(o)];
    counted = M_HTRANS[MW'(o)][1];
    total   = m_beats + int'(counted);
    others  = 1'b0;
    for (int j = 0; j < N; j++) if (j != o && HBUSREQ[MW'(j)]) others = 1'b1;
    nxt = o;
    if ((lock_o && req_o) || (m_locked && counted)) nxt = o;
    else if (req_o && (total < MAXB || !others)) nxt = o;
    else begin
      for (int k = 1; k < N; k++) begin
        if (HBUSREQ[MW'((o + k) % N)]) begin
          nxt = (o + k) % N;
          break;
        end
      end
    end
    m_locked = lock_o && req_o;
    m_downer = o;
    m_beats  = (nxt != o) ? 0 : ((total > MAXB) ? MAXB : total);
    m_owner  = nxt;
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < N; i++) begin
      M_HADDR[i]  = $urandom;
      M_HWDATA[i] = $urandom;
      M_HWRITE[i] = 1'($urandom_range(0, 1));
      M_HSIZE[i]  = 3'($urandom_range(0, 2));
    end
  endtask

  task automatic tick(input logic [N-1:0] req, input logic [N-1:0] lk,
                      input logic [N-1:0][1:0] tr, input logic rdy);
    @(posedge HCLK);
    #1;
    HBUSREQ  = req;
    HLOCK    = lk;
    M_HTRANS = tr;
    HREADY   = rdy;
    randomize_data();
    exp_q.push_back(model_out());
    advance();
  endtask

  task automatic rand_tick();
    logic [N-1:0]      req, lk;
    logic [N-1:0][1:0] tr;
    for (int i = 0; i < N; i++) begin
      req[i] = ($urandom_range(0, 3) != 0);
      lk[i]  = req[i] && ($urandom_range(0, 7) == 0);
      tr[i]  = 2'($urandom_range(0, 3));
    end
    tick(req, lk, tr, $urandom_range(0, 4) != 0);
  endtask

  // Async reset asserted between edges, held over one edge, released mid-cycle.
  task automatic mid_reset();
    @(posedge HCLK);
    #1;
    randomize_data();
    #1;
    HRESETn = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    @(posedge HCLK);
    #1;
    exp_q.push_back(model_out());
    #1;
    HRESETn = 1'b1;
    advance();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("HGRANT",    HGRANT,    e.grant);
        check("HMASTER",   HMASTER,   e.hm);
        check("HMASTER_D", HMASTER_D, e.hmd);
        check("HMASTLOCK", HMASTLOCK, e.lock);
        check("HADDR",     HADDR,     e.addr);
        check("HTRANS",    HTRANS,    e.trans);
        check("HWRITE",    HWRITE,    e.wr);
        check("HSIZE",     HSIZE,     e.size);
        check("HWDATA",    HWDATA,    e.wdata);
      end
    end
  end

  initial begin : stimulus
    localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
    #23 HRESETn = 1'b1;

    // Parked on master 0 with no requests.
    repeat (3) tick('0, '0, {IDLE, IDLE, IDLE}, 1'b1);
    // Master 1 alone takes the bus; data phase follows a cycle later.
    repeat (3) tick(3'b010, '0, {IDLE, NSEQ, IDLE}, 1'b1);
    // Masters 0 and 1 contend: alternate every MAXB completed beats.
    repeat (20) tick(3'b011, '0, {IDLE, NSEQ, NSEQ}, 1'b1);
    // Locked 20-beat burst from master 1 while master 0 keeps requesting.
    repeat (2) tick(3'b010, '0, {IDLE, NSEQ, IDLE}, 1'b1);
    tick(3'b011, 3'b010, {IDLE, NSEQ, NSEQ}, 1'b1);
    repeat (18) tick(3'b011, 3'b010, {IDLE, SEQ, NSEQ}, 1'b1);
    tick(3'b001, 3'b000, {IDLE, SEQ, NSEQ}, 1'b1);
    repeat (3) tick(3'b001, 3'b000, {IDLE, IDLE, NSEQ}, 1'b1);
    // Wait states freeze ownership while requests change.
    repeat (5) tick(3'b010, '0, {IDLE, NSEQ, NSEQ}, 1'b0);
    repeat (3) tick(3'b010, '0, {IDLE, NSEQ, IDLE}, 1'b1);
    // Master 2 and master 0 contend while master 1 idles: wrap-around search.
    repeat (12) tick(3'b101, '0, {NSEQ, IDLE, NSEQ}, 1'b1);

    repeat (300) rand_tick();

    // Reset in the middle of a master-1 burst.
    repeat (3) tick(3'b010, '0, {IDLE, NSEQ, IDLE}, 1'b1);
    mid_reset();
    repeat (3) tick(3'b010, '0, {IDLE, SEQ, IDLE}, 1'b1);

    repeat (150) rand_tick();

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge HCLK);
    #2;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
